weight_loader: RTL and testbench
================================

# weight_loader

Byte-stream to AXI4-Lite write master that initialises the synaptic weight store. It sits directly upstream of the synapse weight memory's AXI4-Lite slave port. It assembles 4-byte framed records (synapse index, 16-bit weight) from a host byte channel and issues one single-beat AXI4-Lite write per record. An optional read-back verify follows each write. Out-of-range indices, framing errors, error responses and verify mismatches are counted, never forwarded.

## Interface
- NUM_SYNAPSES, 207, number of weight words in the downstream store; valid indices 0..NUM_SYNAPSES-1
- BASE_ADDR, 32'h0000_0000, byte address of weight word 0; word i is at BASE_ADDR + 4*i
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  8  record byte
- in_valid  in  1  byte valid
- in_last  in  1  marks final byte of a record
- in_ready  out  1  byte accepted when in_valid & in_ready
- verify_en  in  1  enables read-back verify; latched when a record completes
- m_axi_awaddr / awvalid / awready  out / out / in  32 / 1 / 1  write address channel
- m_axi_wdata / wstrb / wvalid / wready  out / out / out / in  32 / 4 / 1 / 1  write data channel
- m_axi_bresp / bvalid / bready  in / in / out  2 / 1 / 1  write response channel
- m_axi_araddr / arvalid / arready  out / out / in  32 / 1 / 1  read address channel
- m_axi_rdata / rresp / rvalid / rready  in / in / in / out  32 / 2 / 1 / 1  read data channel
- busy  out  1  high whenever state != COLLECT
- records_done  out  16  count of records written with OKAY response (and verified, if enabled); wraps
- err_count  out  8  errors of any kind; saturates at 255

## Operation
- Record byte order: idx[15:8], idx[7:0], w[15:8], w[7:0]. A 2-bit byte counter tracks position.
- States:
  - COLLECT: in_ready=1. Accepts bytes and advances the counter.
    - in_last on byte 3: record complete.
    - in_last on bytes 0–2: framing error. err_count++, counter to 0, record discarded.
    - Byte 3 without in_last: framing error. Discard, counter to 0, and drop following bytes through the next in_last, which is also consumed.
  - On record complete:
    - idx >= NUM_SYNAPSES: err_count++, stay in COLLECT, no AXI traffic.
    - Otherwise: latch idx, w and verify_en, then go to WRITE.
  - WRITE: awvalid and wvalid asserted together.
    - Each is held until its own handshake and drops the cycle after it; the two handshakes are independent and may occur in either order or the same cycle.
    - When both are done, go to WRESP.
    - awaddr = BASE_ADDR + {idx,2'b00} (32-bit add, wrap ignored). wdata = {16'h0,w}. wstrb = 4'b0011.
  - WRESP: bready=1.
    - On bvalid, if bresp != 2'b00: err_count++, go to COLLECT.
    - Else if latched verify_en: go to RADDR.
    - Else: records_done++, go to COLLECT.
  - RADDR: arvalid=1 with araddr = awaddr, held until arready, then go to RDATA.
  - RDATA: rready=1.
    - On rvalid, if rresp==2'b00 and rdata[15:0]==w: records_done++.
    - Otherwise: err_count++.
    - Either way, go to COLLECT.
- Only one outstanding transaction; no bytes are accepted while busy.
- Same-cycle error increments never collide, since at most one error event occurs per cycle.

## Timing
- Reset values:
  - State COLLECT, in_ready=1, busy=0.
  - All AXI valid/ready outputs 0; awaddr, wdata, araddr = 0; wstrb = 0.
  - Counters 0; byte counter 0; resync flag clear.
- Byte 3 accepted at cycle N: awvalid=wvalid=1 registered at N+1, busy=1 at N+1, in_ready=0 at N+1.
- Zero-wait-state slave, no verify: earliest return to COLLECT is 3 cycles after the last handshake.
- records_done and err_count update the cycle after the deciding handshake.
- rst mid-transaction aborts immediately: all valids drop next cycle and the partial record is lost. The slave is reset by the same rst.

## Test plan
- Record 00 05 12 34 with in_last on byte 3, zero-wait slave, verify off → one AW at 0x14 with wdata 0x0000_1234, wstrb 0011; records_done=1, err_count=0.
- Same record with verify on; slave returns rdata 0x0000_1234 then, on a second run, 0x0000_1235 → records_done=1 after first; err_count=1 after second; AR address 0x14 both times.
- Index 00 CF (207) → no AW/W/AR activity; err_count=1; in_ready stays 1.
- in_last on byte 1, then a valid record 00 00 AB CD → err_count=1, then write to 0x00 of 0xABCD.
- Slave delays awready by 3 cycles and raises wready immediately; then bresp=2'b10 → awvalid/wvalid each drop one cycle after their own handshake; err_count=1, records_done=0.
- rst pulsed while in WRESP → all outputs at reset values next cycle; a following record is written normally.

Source files
------------

// File: rtl/weight_loader.sv
// Byte-stream to AXI4-Lite write master for the synapse weight store.
// Frames 4-byte records (index, weight), writes each one, and optionally reads it back to verify.
module weight_loader #(
    parameter int          NUM_SYNAPSES = 207,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        verify_en,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy,
    output logic [15:0] records_done,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        WRITE   = 3'd1,
        WRESP   = 3'd2,
        RADDR   = 3'd3,
        RDATA   = 3'd4
    } state_t;

    localparam logic [16:0] IDX_LIMIT = 17'(NUM_SYNAPSES);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic        resync;
    logic [23:0] rec_buf;
    logic [15:0] w_q;
    logic        verify_q;
    logic        aw_done;
    logic        w_done;

    logic        accept;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_fin;
    logic        w_fin;
    logic [15:0] rec_idx;
    logic [15:0] rec_w;
    logic        unused_rdata_hi;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return BASE_ADDR + {14'd0, idx, 2'b00};
    endfunction

    assign in_ready = (state == COLLECT);
    assign busy     = (state != COLLECT);
    assign accept   = in_valid && in_ready;
    assign aw_hs    = m_axi_awvalid && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign aw_fin   = aw_done || aw_hs;
    assign w_fin    = w_done || w_hs;
    // The first three bytes sit in rec_buf when byte 3 arrives on in_data.
    assign rec_idx  = rec_buf[23:8];
    assign rec_w    = {rec_buf[7:0], in_data};
    assign unused_rdata_hi = ^m_axi_rdata[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            byte_cnt      <= 2'd0;
            resync        <= 1'b0;
            rec_buf       <= 24'd0;
            w_q           <= 16'd0;
            verify_q      <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awaddr  <= 32'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= 32'd0;
            m_axi_wstrb   <= 4'd0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= 32'd0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            records_done  <= 16'd0;
            err_count     <= 8'd0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (resync) begin
                            // Dropping bytes until the stream realigns on in_last.
                            byte_cnt <= 2'd0;
                            if (in_last) begin
                                resync <= 1'b0;
                            end
                        end else begin
                            rec_buf <= {rec_buf[15:0], in_data};
                            if (byte_cnt == 2'd3) begin
                                byte_cnt <= 2'd0;
                                if (!in_last) begin
                                    resync    <= 1'b1;
                                    err_count <= sat_inc8(err_count);
                                end else if ({1'b0, rec_idx} >= IDX_LIMIT) begin
                                    err_count <= sat_inc8(err_count);
                                end else begin
                                    w_q           <= rec_w;
                                    verify_q      <= verify_en;
                                    m_axi_awaddr  <= word_addr(rec_idx);
                                    m_axi_wdata   <= {16'd0, rec_w};
                                    m_axi_wstrb   <= 4'b0011;
                                    m_axi_awvalid <= 1'b1;
                                    m_axi_wvalid  <= 1'b1;
                                    aw_done       <= 1'b0;
                                    w_done        <= 1'b0;
                                    state         <= WRITE;
                                end
                            end else if (in_last) begin
                                byte_cnt  <= 2'd0;
                                err_count <= sat_inc8(err_count);
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                    end
                end
                WRITE: begin
                    // Address and data handshakes complete independently.
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        m_axi_bready <= 1'b1;
                        state        <= WRESP;
                    end else begin
                        aw_done <= aw_fin;
                        w_done  <= w_fin;
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            err_count <= sat_inc8(err_count);
                            state     <= COLLECT;
                        end else if (verify_q) begin
                            m_axi_araddr  <= m_axi_awaddr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RADDR;
                        end else begin
                            records_done <= records_done + 16'd1;
                            state        <= COLLECT;
                        end
                    end
                end
                RADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        if (m_axi_rresp == 2'b00 && m_axi_rdata[15:0] == w_q) begin
                            records_done <= records_done + 16'd1;
                        end else begin
                            err_count <= sat_inc8(err_count);
                        end
                        state <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: AXI4-Lite slave model with a word memory,
// directed scenarios plus randomized records against a record-level reference model.
module tb_weight_loader;

    localparam int NS = 207;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        verify_en;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        busy;
    logic [15:0] records_done;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    weight_loader #(.NUM_SYNAPSES(NS), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .verify_en(verify_en),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy), .records_done(records_done), .err_count(err_count)
    );

    // Slave configuration, set by the tests before each record.
    int          aw_delay;
    int          w_delay;
    logic [1:0]  cfg_bresp;
    logic [1:0]  cfg_rresp;
    logic [31:0] cfg_rxor;
    bit          cfg_bhold;

    int          aw_wait;
    int          w_wait;
    bit          aw_got;
    bit          w_got;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [31:0] mem [0:255];

    logic [31:0] q_aw[$];
    logic [31:0] q_wd[$];
    logic [3:0]  q_ws[$];
    logic [31:0] q_ar[$];

    logic [31:0] exp_aw[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_ar[$];
    int          exp_rec;
    int          exp_err;

    int passed = 0;
    int total  = 0;

    always_comb begin
        awready = awvalid && !aw_got && (aw_wait >= aw_delay);
        wready  = wvalid && !w_got && (w_wait >= w_delay);
        arready = arvalid && !rvalid;
    end

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'd0;
        end else begin
            if (awvalid && !aw_got) begin
                if (awready) begin
                    aw_got <= 1'b1; aw_addr_q <= awaddr; aw_wait <= 0; q_aw.push_back(awaddr);
                end else begin
                    aw_wait <= aw_wait + 1;
                end
            end
            if (wvalid && !w_got) begin
                if (wready) begin
                    w_got <= 1'b1; w_data_q <= wdata; w_wait <= 0;
                    q_wd.push_back(wdata); q_ws.push_back(wstrb);
                end else begin
                    w_wait <= w_wait + 1;
                end
            end
            if (aw_got && w_got && !bvalid && !cfg_bhold) begin
                bvalid <= 1'b1; bresp <= cfg_bresp;
                mem[aw_addr_q[9:2]] <= w_data_q;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1; rresp <= cfg_rresp;
                rdata <= mem[araddr[9:2]] ^ cfg_rxor;
                q_ar.push_back(araddr);
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    task automatic clear_queues();
        q_aw.delete(); q_wd.delete(); q_ws.delete(); q_ar.delete();
        exp_aw.delete(); exp_wd.delete(); exp_ar.delete();
        exp_rec = 0; exp_err = 0;
    endtask

    task automatic reset_dut();
        aw_delay = 0; w_delay = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
        cfg_rxor = 32'd0; cfg_bhold = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0; verify_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_queues();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit ven);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_byte_timeout in_ready=%0b required 1", in_ready);
        end
        in_data = b; in_valid = 1'b1; in_last = last; verify_en = ven;
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_record(input logic [15:0] idx, input logic [15:0] w, input bit ven);
        send_byte(idx[15:8], 1'b0, ven);
        send_byte(idx[7:0], 1'b0, ven);
        send_byte(w[15:8], 1'b0, ven);
        send_byte(w[7:0], 1'b1, ven);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            $display("FAIL %s idle_timeout busy=%0b required 0", name, busy);
        end
    endtask

    // Record-level reference: what a record should cause on the bus and in the counters.
    task automatic model_record(input logic [15:0] idx, input logic [15:0] w, input bit ven);
        if (int'(idx) >= NS) begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end else begin
            exp_aw.push_back(32'(idx) * 4);
            exp_wd.push_back({16'd0, w});
            if (cfg_bresp != 2'b00) begin
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            end else if (ven) begin
                exp_ar.push_back(32'(idx) * 4);
                if (cfg_rresp == 2'b00 && cfg_rxor[15:0] == 16'd0) exp_rec = (exp_rec + 1) % 65536;
                else exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            end else begin
                exp_rec = (exp_rec + 1) % 65536;
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        total++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) $display("FAIL reset_valids got=%b required 00000", {awvalid, wvalid, arvalid, bready, rready}); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b required 1", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b required 0", busy); else passed++;
        total++; if (awaddr !== 32'd0) $display("FAIL reset_awaddr got=%h required 0", awaddr); else passed++;
        total++; if (wdata !== 32'd0) $display("FAIL reset_wdata got=%h required 0", wdata); else passed++;
        total++; if (wstrb !== 4'd0) $display("FAIL reset_wstrb got=%b required 0000", wstrb); else passed++;
        total++; if (araddr !== 32'd0) $display("FAIL reset_araddr got=%h required 0", araddr); else passed++;
        total++; if (records_done !== 16'd0) $display("FAIL reset_records got=%0d required 0", records_done); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL reset_err got=%0d required 0", err_count); else passed++;
    endtask

    task automatic test_basic_write();
        reset_dut();
        send_record(16'h0005, 16'h1234, 1'b0);
        total++; if ({awvalid, wvalid, busy, in_ready} !== 4'b1110) $display("FAIL basic_first_cycle aw/w/busy/rdy got=%b required 1110", {awvalid, wvalid, busy, in_ready}); else passed++;
        wait_idle("basic");
        total++; if (q_aw.size() != 1 || q_aw[0] !== 32'h14) $display("FAIL basic_awaddr got=%h n=%0d required 00000014", (q_aw.size() > 0) ? q_aw[0] : 32'hx, q_aw.size()); else passed++;
        total++; if (q_wd.size() != 1 || q_wd[0] !== 32'h1234) $display("FAIL basic_wdata got=%h required 00001234", (q_wd.size() > 0) ? q_wd[0] : 32'hx); else passed++;
        total++; if (q_ws.size() != 1 || q_ws[0] !== 4'b0011) $display("FAIL basic_wstrb got=%b required 0011", (q_ws.size() > 0) ? q_ws[0] : 4'hx); else passed++;
        total++; if (q_ar.size() != 0) $display("FAIL basic_no_read got=%0d reads required 0", q_ar.size()); else passed++;
        total++; if (records_done !== 16'd1 || err_count !== 8'd0) $display("FAIL basic_counters rec=%0d err=%0d required 1/0", records_done, err_count); else passed++;
    endtask

    task automatic test_verify();
        reset_dut();
        send_record(16'h0005, 16'h1234, 1'b1);
        wait_idle("verify_ok");
        total++; if (q_ar.size() != 1 || q_ar[0] !== 32'h14) $display("FAIL verify_ok_araddr got=%h n=%0d required 00000014", (q_ar.size() > 0) ? q_ar[0] : 32'hx, q_ar.size()); else passed++;
        total++; if (records_done !== 16'd1 || err_count !== 8'd0) $display("FAIL verify_ok_counters rec=%0d err=%0d required 1/0", records_done, err_count); else passed++;
        cfg_rxor = 32'h0000_0001;
        send_record(16'h0005, 16'h1234, 1'b1);
        wait_idle("verify_bad");
        total++; if (q_ar.size() != 2 || q_ar[1] !== 32'h14) $display("FAIL verify_bad_araddr n=%0d required 2 reads at 00000014", q_ar.size()); else passed++;
        total++; if (records_done !== 16'd1 || err_count !== 8'd1) $display("FAIL verify_bad_counters rec=%0d err=%0d required 1/1", records_done, err_count); else passed++;
    endtask

    task automatic test_out_of_range();
        bit bad;
        reset_dut();
        send_record(16'd207, 16'h1234, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!in_ready || busy || awvalid || wvalid || arvalid) bad = 1'b1;
        end
        total++; if (bad) $display("FAIL range_idle got=activity required in_ready=1 and no valids"); else passed++;
        total++; if (q_aw.size() + q_wd.size() + q_ar.size() != 0) $display("FAIL range_no_axi got=%0d transfers required 0", q_aw.size() + q_wd.size() + q_ar.size()); else passed++;
        total++; if (err_count !== 8'd1 || records_done !== 16'd0) $display("FAIL range_counters err=%0d rec=%0d required 1/0", err_count, records_done); else passed++;
        send_record(16'd206, 16'h0042, 1'b0);
        wait_idle("range_edge");
        total++; if (q_aw.size() != 1 || q_aw[0] !== 32'd824) $display("FAIL range_last_index got n=%0d required one write at 00000338", q_aw.size()); else passed++;
    endtask

    task automatic test_framing();
        reset_dut();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (err_count !== 8'd1 || q_aw.size() != 0) $display("FAIL framing_early err=%0d writes=%0d required 1/0", err_count, q_aw.size()); else passed++;
        send_record(16'h0000, 16'hABCD, 1'b0);
        wait_idle("framing");
        total++; if (q_aw.size() != 1 || q_aw[0] !== 32'h0 || q_wd[0] !== 32'hABCD) $display("FAIL framing_recover n=%0d required one write 0000abcd at 0", q_aw.size()); else passed++;
        total++; if (records_done !== 16'd1 || err_count !== 8'd1) $display("FAIL framing_counters rec=%0d err=%0d required 1/1", records_done, err_count); else passed++;
    endtask

    task automatic test_resync();
        reset_dut();
        send_byte(8'h00, 1'b0, 1'b0); send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0); send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0); send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0); send_byte(8'h03, 1'b1, 1'b0);
        send_record(16'h0002, 16'h5566, 1'b0);
        wait_idle("resync");
        total++; if (q_aw.size() != 1 || q_aw[0] !== 32'h8 || q_wd[0] !== 32'h5566) $display("FAIL resync_writes n=%0d first=%h required one write at 00000008", q_aw.size(), (q_aw.size() > 0) ? q_aw[0] : 32'hx); else passed++;
        total++; if (records_done !== 16'd1) $display("FAIL resync_records got=%0d required 1", records_done); else passed++;
    endtask

    task automatic test_slow_aw_bresp_err();
        bit aw_prev, w_prev;
        int aw_n, w_n, n;
        reset_dut();
        aw_delay = 3; cfg_bresp = 2'b10;
        send_record(16'h0005, 16'h1234, 1'b0);
        aw_prev = 1'b0; w_prev = 1'b0; aw_n = 0; w_n = 0; n = 0;
        while (n < 60 && (busy || n == 0)) begin
            @(negedge clk);
            if (aw_prev) begin
                total++; if (awvalid !== 1'b0) $display("FAIL slow_awvalid_drop got=%0b required 0", awvalid); else passed++;
            end
            if (w_prev) begin
                total++; if (wvalid !== 1'b0) $display("FAIL slow_wvalid_drop got=%0b required 0", wvalid); else passed++;
                total++; if (awvalid !== 1'b1) $display("FAIL slow_aw_held got=%0b required 1", awvalid); else passed++;
            end
            aw_prev = awvalid && awready;
            w_prev  = wvalid && wready;
            if (aw_prev) aw_n++;
            if (w_prev) w_n++;
            n++;
        end
        total++; if (aw_n != 1 || w_n != 1) $display("FAIL slow_handshakes aw=%0d w=%0d required 1/1", aw_n, w_n); else passed++;
        total++; if (err_count !== 8'd1 || records_done !== 16'd0) $display("FAIL slow_counters err=%0d rec=%0d required 1/0", err_count, records_done); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        reset_dut();
        cfg_bhold = 1'b1;
        send_record(16'h0007, 16'hBEEF, 1'b0);
        n = 0;
        @(negedge clk);
        while (!bready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (bready !== 1'b1) $display("FAIL midrst_reach_wresp bready=%0b required 1", bready); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if ({awvalid, wvalid, arvalid, bready, rready, busy, in_ready} !== 7'b0000001) $display("FAIL midrst_controls got=%b required 0000001", {awvalid, wvalid, arvalid, bready, rready, busy, in_ready}); else passed++;
        total++; if (awaddr !== 32'd0 || wdata !== 32'd0 || wstrb !== 4'd0 || araddr !== 32'd0) $display("FAIL midrst_data aw=%h wd=%h ws=%b ar=%h required zeros", awaddr, wdata, wstrb, araddr); else passed++;
        rst = 1'b0;
        cfg_bhold = 1'b0;
        clear_queues();
        send_record(16'h0009, 16'h1111, 1'b0);
        wait_idle("midrst");
        total++; if (q_aw.size() != 1 || q_aw[0] !== 32'h24 || q_wd[0] !== 32'h1111) $display("FAIL midrst_after n=%0d required one write 00001111 at 00000024", q_aw.size()); else passed++;
        total++; if (records_done !== 16'd1 || err_count !== 8'd0) $display("FAIL midrst_counters rec=%0d err=%0d required 1/0", records_done, err_count); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] idx, w;
        logic [31:0] e;
        bit ven;
        int k;
        reset_dut();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, 3);
                for (int b = 1; b <= k; b++) send_byte(8'($urandom), (b == k), 1'b0);
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                repeat (2) @(negedge clk);
            end else begin
                idx = 16'($urandom_range(0, 230));
                w = 16'($urandom);
                ven = 1'($urandom);
                aw_delay = $urandom_range(0, 3);
                w_delay = $urandom_range(0, 3);
                cfg_bresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
                cfg_rresp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
                cfg_rxor = ($urandom_range(0, 5) == 0) ? (32'd1 << $urandom_range(0, 15)) : 32'd0;
                model_record(idx, w, ven);
                send_record(idx, w, ven);
                wait_idle("random");
                repeat (1) @(negedge clk);
            end
            while (exp_aw.size() > 0) begin
                e = exp_aw.pop_front();
                total++; if (q_aw.size() == 0 || q_aw[0] !== e) $display("FAIL rand_awaddr it=%0d got=%h required %h", it, (q_aw.size() > 0) ? q_aw[0] : 32'hx, e); else passed++;
                if (q_aw.size() > 0) void'(q_aw.pop_front());
                e = exp_wd.pop_front();
                total++; if (q_wd.size() == 0 || q_wd[0] !== e) $display("FAIL rand_wdata it=%0d got=%h required %h", it, (q_wd.size() > 0) ? q_wd[0] : 32'hx, e); else passed++;
                if (q_wd.size() > 0) void'(q_wd.pop_front());
            end
            while (exp_ar.size() > 0) begin
                e = exp_ar.pop_front();
                total++; if (q_ar.size() == 0 || q_ar[0] !== e) $display("FAIL rand_araddr it=%0d got=%h required %h", it, (q_ar.size() > 0) ? q_ar[0] : 32'hx, e); else passed++;
                if (q_ar.size() > 0) void'(q_ar.pop_front());
            end
            total++; if (q_aw.size() + q_ar.size() != 0) $display("FAIL rand_extra_traffic it=%0d got=%0d required 0", it, q_aw.size() + q_ar.size()); else passed++;
            q_ws.delete(); q_wd.delete();
            total++; if (records_done !== 16'(exp_rec)) $display("FAIL rand_records it=%0d got=%0d required %0d", it, records_done, exp_rec); else passed++;
            total++; if (err_count !== 8'(exp_err)) $display("FAIL rand_err it=%0d got=%0d required %0d", it, err_count, exp_err); else passed++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic_write();
        test_verify();
        test_out_of_range();
        test_framing();
        test_resync();
        test_slow_aw_bresp_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
